// File: rtl/mat_stream_tx.sv
// -----------------------------------------------------------------------------
// mat_stream_tx
//
// Purpose:
//   Matrix stream transmitter. Holds one operand matrix in a local BRAM. The
//   matrix is loaded through a simple write port and streamed out on an
//   AXI-Stream master, one element per beat, with tlast on the final element.
//   There is one instance per multiplier operand (A or B).
//
// Optional feature (compile-time macro MAT_STREAM_TX_TRANSPOSE_EN):
//   When defined, an extra input 'transpose' is added and sampled with start.
//   If it is set, the row-major storage is streamed column-major. When the
//   macro is undefined, the port and the column-wrap logic do not exist.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   wr_en          in   load-port write strobe (honoured only while idle)
//   wr_addr        in   load-port address, element (r,c) stored at r*cols+c
//   wr_data        in   load-port data
//   start          in   single-cycle transmit request
//   rows, cols     in   matrix shape, sampled when start is accepted
//   transpose      in   (macro only) stream column-major
//   busy           out  transfer in progress
//   done           out  one-cycle pulse when a transfer completes
//   err            out  one-cycle pulse when start is rejected (too large)
//   m_axis_tdata   out  element data
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  final element of the matrix
//   dbg_state      out  FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: a beat transfers on a rising edge where tvalid && tready. Once
// tvalid is high, tdata/tlast hold until that transfer. tvalid comes only
// from registered FIFO occupancy, so it never depends on tready in the same
// cycle.
// -----------------------------------------------------------------------------
module mat_stream_tx #(
  parameter int D_W          = 8,
  parameter int MATRIXSIZE_W = 24,
  parameter int MEM_DEPTH    = 6144,
  parameter int ADDR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [D_W-1:0]          wr_data,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] rows,
  input  logic [MATRIXSIZE_W-1:0] cols,
`ifdef MAT_STREAM_TX_TRANSPOSE_EN
  input  logic                    transpose,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [D_W-1:0]          m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [1:0]              dbg_state
);

  localparam int TOT_W = 2 * MATRIXSIZE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [D_W-1:0]    mem [MEM_DEPTH];

  logic [TOT_W-1:0]  req_total;
  logic [TOT_W-1:0]  total_q;
  logic [TOT_W-1:0]  issued_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] addr_next;

  // Two-entry output FIFO with a last flag per entry.
  logic [D_W-1:0]    fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  logic              rd_en;
  logic              rd_last;
  logic              pop;
  logic              start_zero;
  logic              start_big;
  logic              start_ok;
  logic              done_d, done_q;
  logic              err_d, err_q;

  assign req_total  = TOT_W'(rows) * TOT_W'(cols);
  assign start_zero = (rows == '0) || (cols == '0);
  assign start_big  = req_total > TOT_W'(MEM_DEPTH);
  assign rd_last    = (issued_q == (total_q - TOT_W'(1)));
  assign pop        = m_axis_tvalid && m_axis_tready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control
  // A read lands directly in the FIFO on the edge that ends its cycle, so
  // there is never a read in flight across an edge. "Occupancy plus in-flight
  // below 2" therefore reduces to count_q < 2.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    start_ok = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_big) begin
            err_d = 1'b1;
          end else if (start_zero) begin
            done_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (count_q < 2'd2) begin
          rd_en = 1'b1;
          if (rd_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // No reads are issued here, so popping the only entry empties the FIFO.
        if (pop && (count_q == 2'd1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation (incremental, no multiplier in the loop)
  // ---------------------------------------------------------------------------
`ifdef MAT_STREAM_TX_TRANSPOSE_EN
  logic                    transpose_q;
  logic [MATRIXSIZE_W-1:0] rows_q;
  logic [MATRIXSIZE_W-1:0] cols_q;
  logic [MATRIXSIZE_W-1:0] row_idx_q;
  logic [ADDR_W-1:0]       col_q;
  logic                    col_end;

  // Column-major walk: step by cols down a column, then wrap to the top of
  // the next column (0, cols, 2cols, ..., 1, cols+1, ...).
  assign col_end = (row_idx_q == (rows_q - MATRIXSIZE_W'(1)));

  always_comb begin
    addr_next = rd_addr_q + ADDR_W'(1);
    if (transpose_q) begin
      if (col_end) begin
        addr_next = col_q + ADDR_W'(1);
      end else begin
        addr_next = rd_addr_q + ADDR_W'(cols_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      transpose_q <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      row_idx_q   <= '0;
      col_q       <= '0;
    end else if (start_ok) begin
      transpose_q <= transpose;
      rows_q      <= rows;
      cols_q      <= cols;
      row_idx_q   <= '0;
      col_q       <= '0;
    end else if (rd_en && transpose_q) begin
      if (col_end) begin
        row_idx_q <= '0;
        col_q     <= col_q + ADDR_W'(1);
      end else begin
        row_idx_q <= row_idx_q + MATRIXSIZE_W'(1);
      end
    end
  end
`else
  assign addr_next = rd_addr_q + ADDR_W'(1);
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q   <= '0;
      issued_q  <= '0;
      rd_addr_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_q + {1'b0, rd_en} - {1'b0, pop};
      if (rd_en) wr_ptr_q <= ~wr_ptr_q;
      if (pop)   rd_ptr_q <= ~rd_ptr_q;
      if (start_ok) begin
        total_q   <= req_total;
        issued_q  <= '0;
        rd_addr_q <= '0;
      end else if (rd_en) begin
        issued_q  <= issued_q + TOT_W'(1);
        rd_addr_q <= addr_next;
      end
    end
  end

  // BRAM write port and synchronous read straight into the FIFO slot.
  // BRAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE) &&
        ({1'b0, wr_addr} < (ADDR_W + 1)'(MEM_DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      fifo_data[wr_ptr_q] <= mem[rd_addr_q];
      fifo_last[wr_ptr_q] <= rd_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // When count is 1, a push goes to the other slot, so the head holds steady
  // while a beat waits. Data and last are forced to 0 while not valid.
  // ---------------------------------------------------------------------------
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr_q];
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mat_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_mat_stream_tx
//
// Directed bench for mat_stream_tx. A value labelled "at T0+n" is registered
// by the n-1'th edge after the edge T0 that samples start, so it is sampled
// with cyc == T0+n-1.
// -----------------------------------------------------------------------------
module tb_mat_stream_tx;

  localparam int D_W          = 8;
  localparam int MATRIXSIZE_W = 24;
  localparam int MEM_DEPTH    = 6144;
  localparam int ADDR_W       = $clog2(MEM_DEPTH);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    wr_en = 1'b0;
  logic [ADDR_W-1:0]       wr_addr = '0;
  logic [D_W-1:0]          wr_data = '0;
  logic                    start = 1'b0;
  logic [MATRIXSIZE_W-1:0] rows = '0;
  logic [MATRIXSIZE_W-1:0] cols = '0;
`ifdef MAT_STREAM_TX_TRANSPOSE_EN
  logic                    transpose = 1'b0;
`endif
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [D_W-1:0]          m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready = 1'b1;
  logic                    m_axis_tlast;
  logic [1:0]              dbg_state;

  mat_stream_tx dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .start         (start),
    .rows          (rows),
    .cols          (cols),
`ifdef MAT_STREAM_TX_TRANSPOSE_EN
    .transpose     (transpose),
`endif
    .busy          (busy),
    .done          (done),
    .err           (err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int t0       = 0;

  logic [D_W-1:0] exp_q[$];
  logic [D_W-1:0] cap_d[$];
  logic           cap_l[$];
  int             cap_c[$];
  int             done_cnt = 0;
  int             done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- output monitor ----------------
  logic           prev_stall = 1'b0;
  logic [D_W-1:0] prev_d = '0;
  logic           prev_l = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", 32'(m_axis_tdata), 32'(prev_d));
        check("stall_last", 32'(m_axis_tlast), 32'(prev_l));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_d.push_back(m_axis_tdata);
        cap_l.push_back(m_axis_tlast);
        cap_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int addr, input logic [D_W-1:0] val);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = val;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) load(i, D_W'(i + 1));
  endtask

  task automatic start_xfer(input int r, input int c, input logic tp);
    cap_d.delete();
    cap_l.delete();
    cap_c.delete();
    done_cnt = 0;
    rows  = MATRIXSIZE_W'(r);
    cols  = MATRIXSIZE_W'(c);
`ifdef MAT_STREAM_TX_TRANSPOSE_EN
    transpose = tp;
`else
    if (tp) $display("note: transpose requested but not built in");
`endif
    start = 1'b1;
    step(1);
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1);
      n++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic timed);
    int n;
    n = exp_q.size();
    check({tag, "_count"}, 32'(cap_d.size()), 32'(n));
    for (int k = 0; k < n && k < cap_d.size(); k++) begin
      check({tag, "_data"}, 32'(cap_d[k]), 32'(exp_q[k]));
      check({tag, "_last"}, 32'(cap_l[k]), 32'(k == n - 1));
      if (timed) check({tag, "_cyc"}, 32'(cap_c[k]), 32'(t0 + 1 + k));
    end
    if (timed) check({tag, "_done_cyc"}, 32'(done_cyc), 32'(t0 + n + 1));
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step(1);

    // 2x3 matrix 1..6, tready high
    load_seq(6);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    start_xfer(2, 3, 1'b0);
    check("run_busy_t0p1", 32'(busy), 32'd1);
    check("run_tvalid_t0p1", 32'(m_axis_tvalid), 32'd0);
    wait_done(30);
    check_stream("rm", 1'b1);
    check("rm_busy_after", 32'(busy), 32'd0);

    // Same matrix with tready toggling
    start_xfer(2, 3, 1'b0);
    for (int i = 0; i < 60 && done_cnt == 0; i++) begin
      m_axis_tready = (i % 2 == 1);
      step(1);
    end
    m_axis_tready = 1'b1;
    check("bp_done_seen", 32'(done_cnt != 0), 32'd1);
    check_stream("bp", 1'b0);

    // Zero-size transfer
    start_xfer(0, 3, 1'b0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_tvalid", 32'(m_axis_tvalid), 32'd0);
    step(3);
    check("zero_done_pulse", 32'(done), 32'd0);
    check("zero_no_beats", 32'(cap_d.size()), 32'd0);

    // Oversize request: 5*1229 = 6145
    start_xfer(5, 1229, 1'b0);
    check("big_err", 32'(err), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    check("big_done", 32'(done), 32'd0);
    step(1);
    check("big_err_pulse", 32'(err), 32'd0);

    // Exactly full capacity is accepted; abort it with reset
    start_xfer(1, 6144, 1'b0);
    check("full_busy", 32'(busy), 32'd1);
    check("full_err", 32'(err), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("full_rst_busy", 32'(busy), 32'd0);
    step(1);

    // 4x4 transfer, reset after third beat, then restart
    for (int i = 0; i < 16; i++) load(i, D_W'(8'h20 + i));
    start_xfer(4, 4, 1'b0);
    for (int i = 0; i < 20 && cap_d.size() < 3; i++) step(1);
    check("mid_beats_before_rst", 32'(cap_d.size()), 32'd3);
    rst = 1'b1;
    step(1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step(6);
    check("mid_no_done", 32'(done_cnt), 32'd0);
    check("mid_no_more_beats", 32'(cap_d.size()), 32'd3);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(D_W'(8'h20 + i));
    start_xfer(4, 4, 1'b0);
    wait_done(40);
    check_stream("restart", 1'b1);

    // start and write while busy are ignored
    load_seq(6);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    start_xfer(2, 3, 1'b0);
    rows    = '0;
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 8'hEE;
    step(1);
    start = 1'b0;
    wr_en = 1'b0;
    check("ign_err", 32'(err), 32'd0);
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(30);
    check_stream("ign", 1'b1);
    start_xfer(2, 3, 1'b0);
    wait_done(30);
    check_stream("ign_mem", 1'b1);

`ifdef MAT_STREAM_TX_TRANSPOSE_EN
    // Column-major stream of the 2x3 matrix
    exp_q = '{8'd1, 8'd4, 8'd2, 8'd5, 8'd3, 8'd6};
    start_xfer(2, 3, 1'b1);
    wait_done(30);
    check_stream("tp", 1'b1);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mat_stream_tx.md
# mat_stream_tx

Matrix stream transmitter: the source end of the multiplier's AXI-Stream operand inputs. It holds one operand matrix in a local BRAM that is loaded through a simple write port, then streams it out one element per beat on an AXI-Stream master, with `tlast` on the final element. It drives the A or B operand stream, one instance per operand, so the accelerator can be fed from on-chip data without an external DMA.

## Interface
- `D_W`, 8: element width in bits.
- `MATRIXSIZE_W`, 24: width of the row and column count inputs.
- `MEM_DEPTH`, 6144: element capacity of the local BRAM.
- `ADDR_W`, `$clog2(MEM_DEPTH)`: BRAM address width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: load-port write strobe.
- `wr_addr` in `ADDR_W`: load-port address; matrix stored row-major, element (r,c) at r*cols+c.
- `wr_data` in `D_W`: load-port data.
- `start` in 1: single-cycle request to transmit the stored matrix.
- `rows` in `MATRIXSIZE_W`: row count, sampled when `start` is accepted.
- `cols` in `MATRIXSIZE_W`: column count, sampled when `start` is accepted.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.
- `err` out 1: one-cycle pulse when `start` is rejected.
- `m_axis_tdata` out `D_W`: element data.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: marks the final element of the matrix.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `wr_en` writes the BRAM. Writes are ignored in RUN and DRAIN.
  - `start` with rows*cols > `MEM_DEPTH` pulses `err` and the FSM stays in IDLE.
  - `start` with rows==0 or cols==0 pulses `done` and emits no beats.
  - Otherwise `start` latches `rows` and `cols`, computes total = rows*cols (2*`MATRIXSIZE_W`-bit product), clears the counters and goes to RUN.
- **RUN:** issues one BRAM read per cycle whenever the output buffer has a free slot, until total reads have been issued, then goes to DRAIN.
- **DRAIN:** waits for the buffer to empty, then pulses `done` and returns to IDLE.
- **Output buffer:** 2-entry skid FIFO after the 1-cycle BRAM read. It sustains one beat per cycle with `tready` held high.
  - Reads are issued only when FIFO occupancy plus in-flight reads is less than 2.
  - The FIFO never overflows and never drops data.
- **AXI rules:**
  - Once `tvalid` is asserted, `tdata` and `tlast` stay stable until `tvalid && tready`.
  - `tvalid` does not depend combinationally on `tready`.
- **`tlast`:** set on exactly one beat, the element with read index total-1. Each read carries a `last` bit through the FIFO.
- **Address generation:** incremental only, no multiplier in the loop.
  - Row-major: addr increments by 1 per read.
- **Simultaneous events:**
  - `start` while busy is ignored, with no `err`.
  - `wr_en` together with an accepted `start` in IDLE: the write completes.
- **Reset mid-transfer:** on the next edge the FSM returns to IDLE, the FIFO and counters clear, and all outputs drop. No `done` is produced. BRAM contents are retained.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- **`start` acceptance:** `start` is sampled at edge T0.
  - `busy`=1 from T0+1.
  - First BRAM read is issued at T0+1.
  - First `tvalid` at T0+2.
- **Throughput:** with `tready`=1 throughout, beat k is presented at T0+2+k. Last beat at T0+1+total.
- **Backpressure:** `tready` low for n cycles stalls the stream by exactly n cycles, with no bubbles after release.
- **`done`:** asserted in the cycle after the handshake carrying `tlast`; `busy` deasserts in that same cycle.
- **Zero-size transfer:** `done` at T0+1, `busy` stays 0.
- **Rejected start:** `err` at T0+1, `busy` stays 0.
- **Back-to-back:** a new `start` is accepted in the cycle `done` is high.

## Configuration
- **`MAT_STREAM_TX_TRANSPOSE_EN`:**
  - **Defined:** adds input `transpose` (1 bit), sampled with `start`.
    - When set, the matrix is emitted column-major (the transposed stream) from the same row-major storage.
    - Address steps by `cols` per read; at the end of a column it wraps to the next column index (0, cols, 2cols, …, then 1, cols+1, …).
    - `tlast` and `done` rules are unchanged.
  - **Undefined:** no `transpose` port; row-major only; no column-wrap logic is instantiated.

## Test plan
- Load a 2x3 matrix with values 1..6, start, `tready`=1 → beats 1,2,3,4,5,6 at T0+2..T0+7; `tlast` on 6; `done` at T0+8.
- Same 2x3 matrix, `tready` toggling 1,0,1,0… → same six values in order; `tdata` stable during stalls; exactly one `tlast`.
- `rows`=0 → `done` at T0+1, no `tvalid`. `rows`*`cols`=6145 → `err` at T0+1, `busy`=0.
- Reset asserted after the 3rd beat of a 4x4 transfer → all outputs 0 next cycle, no `done`; a restart streams all 16 beats correctly.
- With `MAT_STREAM_TX_TRANSPOSE_EN` and `transpose`=1 on the 2x3 matrix 1..6 → beats 1,4,2,5,3,6 with `tlast` on 6.
- `start` pulsed while busy, and `wr_en` to address 0 while busy → both ignored; the stream and BRAM contents are unchanged.
